// File: rtl/cpu_send_arbiter.sv
// cpu_send_arbiter: round-robin, burst-bounded arbiter in front of the DPI send channel.
// Define CPU_ARB_TAG_EN to add the out_src requester-index port.
module cpu_send_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_vld,
    output logic [NUM_REQ-1:0]         req_rdy,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [DATA_W-1:0]          out_data
`ifdef CPU_ARB_TAG_EN
    ,
    output logic [$clog2(NUM_REQ)-1:0] out_src
`endif
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, GRANT} state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  owner_q;
    logic [CNT_W-1:0]  burst_cnt_q;
    logic              out_vld_q;
    logic [DATA_W-1:0] out_data_q;
`ifdef CPU_ARB_TAG_EN
    logic [IDX_W-1:0]  out_src_q;
`endif

    logic              load_ok;
    logic              owner_vld;
    logic              beat_acc;
    logic              last_beat;
    logic              pick_vld;
    logic [IDX_W-1:0]  pick_d;
    logic [IDX_W-1:0]  owner_nxt;
    logic [DATA_W-1:0] beat;

    assign load_ok   = !out_vld_q || out_rdy;
    assign owner_vld = req_vld[owner_q];
    assign beat      = req_data[int'(owner_q)*DATA_W +: DATA_W];
    assign beat_acc  = (state_q == GRANT) && owner_vld && load_ok;
    assign last_beat = (burst_cnt_q == CNT_W'(MAX_BURST - 1));
    assign owner_nxt = (int'(owner_q) == NUM_REQ - 1) ? '0
                                                      : owner_q + IDX_W'(1);

    always_comb begin
        req_rdy = '0;
        if (state_q == GRANT && load_ok)
            req_rdy[owner_q] = 1'b1;
    end

    // Scan downward so the candidate closest to rr_ptr is written last.
    always_comb begin : rr_pick
        int j;
        j        = 0;
        pick_d   = rr_ptr_q;
        pick_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_REQ)
                j = j - NUM_REQ;
            if (req_vld[IDX_W'(j)]) begin
                pick_d   = IDX_W'(j);
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
`ifdef CPU_ARB_TAG_EN
            out_src_q   <= '0;
`endif
        end else begin
            if (beat_acc) begin
                out_vld_q  <= 1'b1;
                out_data_q <= beat;
`ifdef CPU_ARB_TAG_EN
                out_src_q  <= owner_q;
`endif
            end else if (out_rdy) begin
                out_vld_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        owner_q     <= pick_d;
                        burst_cnt_q <= '0;
                        state_q     <= GRANT;
                    end
                end
                GRANT: begin
                    if (beat_acc) begin
                        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                        if (last_beat) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= owner_nxt;
                        end
                    end else if (load_ok && !owner_vld) begin
                        // Owner went quiet while the sink could take data.
                        state_q  <= IDLE;
                        rr_ptr_q <= owner_nxt;
                    end
                end
            endcase
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
`ifdef CPU_ARB_TAG_EN
    assign out_src  = out_src_q;
`endif

endmodule
